// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter: measures period and high time of an asynchronous input
// waveform in clk_in cycles. Each completed period (rise to rise) is reported
// as a {total, high} pair with a one-cycle valid strobe. A missing rise for
// 2^WIDTH-1 cycles flags the input as stuck and records its level.
module duty_cycle_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] measured_total,
    output logic [WIDTH-1:0] measured_high,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    typedef enum logic {
        ST_SEEK = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sig_d;
    logic                   w_sig_s;
    logic                   w_rise;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_period_cnt;
    logic [WIDTH-1:0]       r_high_cnt;
    logic [WIDTH-1:0]       r_total;
    logic [WIDTH-1:0]       r_high;
    logic                   r_valid;
    logic                   r_stuck;
    logic                   r_stuck_level;

    assign w_sig_s = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_sig_s & ~r_sig_d;

    // Synchronizer chain plus one delayed copy for rising-edge detection;
    // keeps running regardless of enable so a rise on re-enable is not lost.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_sig_d <= w_sig_s;
        end
    end

    // Measurement FSM: SEEK waits for a rise to arm; MEAS counts the period,
    // reports on each rise and drops back to SEEK on timeout or disable.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SEEK;
            r_period_cnt  <= CNT_ZERO;
            r_high_cnt    <= CNT_ZERO;
            r_total       <= CNT_ZERO;
            r_high        <= CNT_ZERO;
            r_valid       <= 1'b0;
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!enable) begin
                r_state      <= ST_SEEK;
                r_period_cnt <= CNT_ZERO;
                r_high_cnt   <= CNT_ZERO;
            end else begin
                case (r_state)
                    ST_SEEK: begin
                        r_period_cnt <= CNT_ZERO;
                        r_high_cnt   <= CNT_ZERO;
                        if (w_rise) begin
                            // The arming rise cycle is the first (high) cycle of the period.
                            r_period_cnt <= CNT_ONE;
                            r_high_cnt   <= CNT_ONE;
                            r_stuck      <= 1'b0;
                            r_state      <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (w_rise) begin
                            r_total      <= r_period_cnt;
                            r_high       <= r_high_cnt;
                            r_valid      <= 1'b1;
                            r_period_cnt <= CNT_ONE;
                            r_high_cnt   <= CNT_ONE;
                        end else if (r_period_cnt == CNT_MAX) begin
                            // No rise within the counter range: 0 % or 100 % duty.
                            r_stuck       <= 1'b1;
                            r_stuck_level <= w_sig_s;
                            r_period_cnt  <= CNT_ZERO;
                            r_high_cnt    <= CNT_ZERO;
                            r_state       <= ST_SEEK;
                        end else begin
                            r_period_cnt <= r_period_cnt + CNT_ONE;
                            if (w_sig_s) begin
                                r_high_cnt <= r_high_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state      <= ST_SEEK;
                        r_period_cnt <= CNT_ZERO;
                        r_high_cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign measured_total = r_total;
    assign measured_high  = r_high;
    assign meas_valid     = r_valid;
    assign stuck          = r_stuck;
    assign stuck_level    = r_stuck_level;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Testbench for duty_cycle_meter: reference model computes results from the
// synchronized level history (period = cycles between rises, high = count of
// high levels in that span); directed scenarios pin the model with literals.
module tb_duty_cycle_meter;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int MAX = (1 << W) - 1;

    logic         clk_in;
    logic         rst_n;
    logic         enable;
    logic         sig_in;
    logic [W-1:0] measured_total;
    logic [W-1:0] measured_high;
    logic         meas_valid;
    logic         stuck;
    logic         stuck_level;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int vcount    = 0;

    duty_cycle_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .enable         (enable),
        .sig_in         (sig_in),
        .measured_total (measured_total),
        .measured_high  (measured_high),
        .meas_valid     (meas_valid),
        .stuck          (stuck),
        .stuck_level    (stuck_level)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit hist[$];     // hist[0] = sig_in sampled at previous edge, older after
    bit lv[$];       // synchronized levels of the period in progress
    bit armed;
    int e_total, e_high;
    bit e_valid, e_stuck, e_lvl;

    function automatic int count_high();
        int n = 0;
        foreach (lv[i]) n += lv[i];
        return n;
    endfunction

    initial begin
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) begin
                hist.delete();
                for (int i = 0; i <= S; i++) hist.push_back(1'b0);
                lv.delete();
                armed = 0; e_total = 0; e_high = 0;
                e_valid = 0; e_stuck = 0; e_lvl = 0;
            end else begin
                bit lvl, prev, rise;
                cyc++;
                lvl  = hist[S-1];
                prev = hist[S];
                rise = lvl & ~prev;
                hist.push_front(sig_in);
                void'(hist.pop_back());
                e_valid = 0;
                if (!enable) begin
                    armed = 0;
                    lv.delete();
                end else if (rise) begin
                    if (armed) begin
                        e_total = lv.size();
                        e_high  = count_high();
                        e_valid = 1;
                    end
                    armed = 1;
                    lv.delete();
                    lv.push_back(1'b1);
                    e_stuck = 0;
                end else if (armed) begin
                    if (lv.size() == MAX) begin
                        e_stuck = 1;
                        e_lvl   = lvl;
                        armed   = 0;
                        lv.delete();
                    end else begin
                        lv.push_back(lvl);
                    end
                end
            end
        end
    end

    // Compare every cycle while out of reset; also count valid strobes.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_n) begin
                chk("cmp_total", 32'(measured_total), e_total);
                chk("cmp_high",  32'(measured_high),  e_high);
                chk("cmp_valid", 32'(meas_valid),     32'(e_valid));
                chk("cmp_stuck", 32'(stuck),          32'(e_stuck));
                chk("cmp_level", 32'(stuck_level),    32'(e_lvl));
                if (meas_valid) begin
                    vcount++;
                    chk("high_le_total", 32'(measured_high <= measured_total), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic run_wave(input int t, input int h, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < t; i++) begin
                @(negedge clk_in);
                sig_in = (i < h);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0, fv, c2, t, h;
        rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        chk("reset_total", 32'(measured_total), 0);
        chk("reset_high",  32'(measured_high),  0);
        chk("reset_valid", 32'(meas_valid),     0);
        chk("reset_stuck", 32'(stuck),          0);
        chk("reset_level", 32'(stuck_level),    0);
        @(negedge clk_in); #2 rst_n = 1'b1; enable = 1'b1;

        // 10/3 generator: one result per period after arming
        run_wave(10, 3, 2);
        #1 v0 = vcount;
        run_wave(10, 3, 5);
        #1;
        chk("gen10_3_valids", vcount - v0, 5);
        chk("gen10_3_total", 32'(measured_total), 10);
        chk("gen10_3_high",  32'(measured_high),  3);

        // enable dropped 4 cycles mid-period
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            sig_in = (i < 3);
            enable = !(i >= 5 && i <= 8);
            if (i == 5) begin
                #1 v0 = vcount;
            end
        end
        run_wave(10, 3, 1);
        #1 chk("abort_no_valid", vcount - v0, 0);
        run_wave(10, 3, 1);
        #1 chk("abort_first_valid", vcount - v0, 1);

        // 2/1 from SEEK: valid 3 edges after the second rise is driven
        @(negedge clk_in); sig_in = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk_in);
        enable = 1'b1;
        repeat (3) @(negedge clk_in);
        fv = -1000; c2 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (meas_valid && fv < 0) fv = cyc;
            sig_in = (k % 2 == 0);
            if (k == 2) c2 = cyc;
        end
        chk("gen2_1_latency", fv - c2, 3);
        run_wave(2, 1, 4);
        #1;
        chk("gen2_1_total", 32'(measured_total), 2);
        chk("gen2_1_high",  32'(measured_high),  1);

        // settings change 10/3 -> 7/5
        run_wave(10, 3, 3);
        run_wave(7, 5, 4);
        #1;
        chk("gen7_5_total", 32'(measured_total), 7);
        chk("gen7_5_high",  32'(measured_high),  5);

        // held high: stuck at level 1, results hold
        @(negedge clk_in); sig_in = 1'b1;
        repeat (200) @(negedge clk_in);
        #1 chk("stuck_hi_early", 32'(stuck), 0);
        repeat (70) @(negedge clk_in);
        #1;
        chk("stuck_hi_flag",  32'(stuck),          1);
        chk("stuck_hi_level", 32'(stuck_level),    1);
        chk("stuck_hi_total", 32'(measured_total), 7);
        chk("stuck_hi_high",  32'(measured_high),  5);
        v0 = vcount;
        run_wave(10, 3, 2);
        #1;
        chk("stuck_cleared", 32'(stuck), 0);
        chk("stuck_rearm_no_valid", vcount - v0, 0);

        // held low: stuck at level 0
        @(negedge clk_in); sig_in = 1'b0;
        repeat (270) @(negedge clk_in);
        #1;
        chk("stuck_lo_flag",  32'(stuck),       1);
        chk("stuck_lo_level", 32'(stuck_level), 0);

        // asynchronous reset mid-period
        run_wave(10, 3, 3);
        @(negedge clk_in); sig_in = 1'b1;
        @(negedge clk_in); sig_in = 1'b0;
        #1 chk("pre_rst_total", 32'(measured_total), 10);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_total", 32'(measured_total), 0);
        chk("async_rst_high",  32'(measured_high),  0);
        chk("async_rst_valid", 32'(meas_valid),     0);
        repeat (2) @(negedge clk_in);
        #2 rst_n = 1'b1;
        #1 v0 = vcount;
        run_wave(10, 3, 1);
        #1 chk("post_rst_arm_only", vcount - v0, 0);
        run_wave(10, 3, 1);
        #1;
        chk("post_rst_first_valid", vcount - v0, 1);
        chk("post_rst_total", 32'(measured_total), 10);
        chk("post_rst_high",  32'(measured_high),  3);

        // randomized periods, duties, occasional timeouts and enable drops
        for (int p = 0; p < 200; p++) begin
            if ($urandom_range(0, 19) == 0) t = $urandom_range(200, 300);
            else t = $urandom_range(2, 24);
            h = $urandom_range(1, t - 1);
            for (int i = 0; i < t; i++) begin
                @(negedge clk_in);
                sig_in = (i < h);
                enable = ($urandom_range(0, 63) != 0);
            end
        end
        enable = 1'b1;
        repeat (5) @(negedge clk_in);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
